fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Decoupling FIFO between instruction-cache fetch and the 4-wide decode stage.
//  Stores fetch packets of {PC, 4 x 32-bit instr, 4-bit lane mask}; mask derives from PC[3:2].
//  Stalls fetch when full, holds decode idle when empty, and empties in one cycle on redirect/kill.
//  First-word-fall-through: the head packet drives decode combinationally from the storage array.
// PARAMETERS
//  DEPTH     8   packet entries; power of two, >= 2
//  WIDTH_PC  32  PC width
//  WIDTH_PTR 3   log2(DEPTH); head/tail pointers, count is WIDTH_PTR+1 bits
// PORTS
//  i_clk      in   1       clock, rising edge
//  i_rst_n    in   1       asynchronous active-low reset
//  i_flush    in   1       redirect/kill: discard all packets
//  i_we       in   1       fetch offers a packet this cycle
//  i_pc       in   32      byte PC of the packet
//  i_data4x   in   128     instr lanes; lane k = [32k+31:32k]
//  o_full     out  1       no free entry; fetch must hold its packet
//  i_re       in   1       decode consumes the head packet
//  o_valid    out  1       head packet present (= !empty)
//  o_pc       out  32      head PC
//  o_data4x   out  128     head instructions
//  o_imask    out  4       head lane-valid mask
//  o_count    out  4       occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): head=tail=0, count=0 -> o_valid=0, o_full=0, o_count=0.
//    Data outputs read 0: they are gated by o_valid, storage is not cleared.
//  - Enqueue: i_we && !o_full at the edge -> write entry[tail]; tail+1 mod DEPTH; count+1.
//    The packet is visible at the head no earlier than the next cycle (1-cycle latency, no bypass).
//  - Dequeue: i_re && o_valid at the edge -> head+1 mod DEPTH; count-1.
//    i_re while empty is ignored.
//  - Simultaneous enqueue and dequeue (both accepted): count unchanged, both pointers advance.
//  - Full: i_we is ignored, data is dropped, and fetch holds its packet. o_full is registered count
//    only; a same-cycle dequeue does NOT open a slot for enqueue (no comb path re_->full).
//  - Flush has priority over both enqueue and dequeue in the same cycle: head=tail=0, count=0.
//    o_valid=0 next cycle. The packet offered in the flush cycle is dropped.
//  - imask, computed at enqueue from i_pc[3:2]: 00->1111, 01->1110, 10->1100, 11->1000.
//    Bit k set = lane k valid; stored alongside data, not recomputed at dequeue.
//  - Wrap-around: pointers wrap naturally; full = (count==DEPTH), empty = (count==0).
//  - o_pc/o_data4x/o_imask = entry[head] when o_valid, else 0.
//  - Reset mid-operation discards all contents immediately (async); the first enqueue after
//    release lands in entry 0.
// STRUCTURE
//  - Shared package/header: FETCH_LANES=4, INSTR_W=32,
//    imask encoding function (pc[3:2] -> 4-bit mask), packet field offsets {pc,imask,data}.
//  - Storage: a reg array of DEPTH x (32+4+128) bits, written at tail. Reset covers only pointers
//    and count.
//  - One natural sub-module: fifo_ctrl (head/tail/count/full/empty with flush priority),
//    reusable by the issue queues.
// TESTING
//  1. Reset, then i_we=1, pc=0x100, data lanes=0x11,0x22,0x33,0x44 -> next cycle o_valid=1,
//     o_pc=0x100, o_imask=1111, o_data4x[31:0]=0x11, o_count=1.
//  2. Enqueue pc=0x108 -> o_imask=1100. Enqueue pc=0x10C -> o_imask=1000. pc=0x104 -> 1110.
//  3. 8 enqueues with no reads -> o_full=1, o_count=8. 9th i_we ignored. Read 8 -> PCs in order,
//     then o_valid=0.
//  4. Full with i_re=1 and i_we=1 in the same cycle -> read accepted, write dropped, o_count=7.
//     Half-full with both -> count unchanged, FIFO order preserved across pointer wrap
//     (run 20 packets).
//  5. count=5, i_flush=1 with i_we=1 and i_re=1 -> next cycle o_count=0, o_valid=0. The next
//     enqueue appears at the head alone.
//  6. Assert i_rst_n=0 off-edge while count=3 -> outputs go to reset values immediately,
//     without waiting for i_clk. Resume enqueues after release -> correct order.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_pkg
// Purpose  : Shared constants, packet field layout and lane-mask helper for
//            the fetch buffer.
// Revision : 1.0  initial release
// ============================================================================
package fetch_buffer_pkg;

  localparam int FETCH_LANES = 4;
  localparam int INSTR_W     = 32;
  localparam int DATA_W      = FETCH_LANES * INSTR_W;
  localparam int IMASK_W     = FETCH_LANES;

  // Packet layout inside one storage entry: {pc, imask, data}
  localparam int DATA_LSB    = 0;
  localparam int IMASK_LSB   = DATA_LSB + DATA_W;
  localparam int PC_LSB      = IMASK_LSB + IMASK_W;

  // A fetch that starts mid-block leaves the lanes below the entry word invalid.
  function automatic logic [IMASK_W-1:0] imask_from_pc(input logic [1:0] word_sel);
    logic [IMASK_W-1:0] mask;
    case (word_sel)
      2'b00:   mask = 4'b1111;
      2'b01:   mask = 4'b1110;
      2'b10:   mask = 4'b1100;
      default: mask = 4'b1000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer_fifo_ctrl
// Purpose  : Head/tail/count bookkeeping for a power-of-two circular queue
//            with a single-cycle flush that overrides push and pop.
// Revision : 1.0  initial release
// ============================================================================
module fetch_buffer_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             push_ok,
  output logic             pop_ok
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Full/empty come straight from the registered count, so a pop in the same
  // cycle never frees a slot for a push (keeps pop off the full timing path).
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;

  // Pointer and occupancy update; flush wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : First-word-fall-through packet FIFO between I-cache fetch and the
//            4-wide decoder. Each entry holds {PC, lane mask, 4 instructions}.
// Revision : 1.0  initial release
// ============================================================================
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH_PC  = 32,
  parameter int WIDTH_PTR = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_we,
  input  logic [WIDTH_PC-1:0]   i_pc,
  input  logic [DATA_W-1:0]     i_data4x,
  output logic                  o_full,
  input  logic                  i_re,
  output logic                  o_valid,
  output logic [WIDTH_PC-1:0]   o_pc,
  output logic [DATA_W-1:0]     o_data4x,
  output logic [IMASK_W-1:0]    o_imask,
  output logic [WIDTH_PTR:0]    o_count
);

  localparam int ENTRY_W = PC_LSB + WIDTH_PC;

  logic [WIDTH_PTR-1:0] head;
  logic [WIDTH_PTR-1:0] tail;
  logic [WIDTH_PTR:0]   count;
  logic                 full;
  logic                 empty;
  logic                 push_ok;
  logic                 pop_ok;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   head_entry;

  fetch_buffer_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (WIDTH_PTR)
  ) u_ctrl (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .flush   (i_flush),
    .push    (i_we),
    .pop     (i_re),
    .head    (head),
    .tail    (tail),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  // Packet storage written at tail; not reset, outputs are gated by valid instead.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[tail] <= {i_pc, imask_from_pc(i_pc[3:2]), i_data4x};
    end
  end

  assign head_entry = mem[head];

  assign o_full   = full;
  assign o_valid  = !empty;
  assign o_count  = count;
  assign o_pc     = empty ? '0 : head_entry[PC_LSB +: WIDTH_PC];
  assign o_imask  = empty ? '0 : head_entry[IMASK_LSB +: IMASK_W];
  assign o_data4x = empty ? '0 : head_entry[DATA_LSB +: DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Self-checking bench for fetch_buffer against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_buffer;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [31:0]  pc = '0;
  logic [127:0] data = '0;

  logic         full;
  logic         valid;
  logic [31:0]  out_pc;
  logic [127:0] out_data;
  logic [3:0]   out_imask;
  logic [3:0]   out_count;

  typedef struct {
    logic [31:0]  pc;
    logic [127:0] data;
  } pkt_t;

  pkt_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_buffer dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_flush  (flush),
    .i_we     (we),
    .i_pc     (pc),
    .i_data4x (data),
    .o_full   (full),
    .i_re     (re),
    .o_valid  (valid),
    .o_pc     (out_pc),
    .o_data4x (out_data),
    .o_imask  (out_imask),
    .o_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Valid lanes are those at or above the word the PC points into.
  function automatic logic [3:0] lane_mask(input logic [31:0] p);
    logic [3:0] m;
    m = 4'b1111;
    return m << p[3:2];
  endfunction

  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    check_val({tag, "_valid"}, valid, (n != 0));
    check_val({tag, "_full"},  full,  (n == DEPTH));
    check_val({tag, "_count"}, out_count, n);
    if (n != 0) begin
      check_val({tag, "_pc"},    out_pc,    q[0].pc);
      check_val({tag, "_data"},  out_data,  q[0].data);
      check_val({tag, "_imask"}, out_imask, lane_mask(q[0].pc));
    end else begin
      check_val({tag, "_pc"},    out_pc,    0);
      check_val({tag, "_data"},  out_data,  0);
      check_val({tag, "_imask"}, out_imask, 0);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, then compare.
  task automatic step(input string tag, input logic w, input logic r, input logic f,
                      input logic [31:0] p, input logic [127:0] d);
    bit can_push, can_pop;
    pkt_t pk;
    we = w; re = r; flush = f; pc = p; data = d;
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      can_push = w && (q.size() < DEPTH);
      can_pop  = r && (q.size() > 0);
      if (can_pop) void'(q.pop_front());
      if (can_push) begin
        pk.pc = p; pk.data = d;
        q.push_back(pk);
      end
    end
    #1;
    we = 1'b0; re = 1'b0; flush = 1'b0;
    check_outputs(tag);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1;
    check_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic enqueue and lane masks
    step("t1", 1, 0, 0, 32'h100, {32'h44, 32'h33, 32'h22, 32'h11});
    check_val("t1_lane0", out_data[31:0], 32'h11);
    check_val("t1_imask", out_imask, 4'b1111);
    step("t2a", 1, 1, 0, 32'h108, rnd128());
    check_val("t2_imask_108", out_imask, 4'b1100);
    step("t2b", 1, 1, 0, 32'h10C, rnd128());
    check_val("t2_imask_10c", out_imask, 4'b1000);
    step("t2c", 1, 1, 0, 32'h104, rnd128());
    check_val("t2_imask_104", out_imask, 4'b1110);
    step("t2d", 0, 1, 0, 0, 0);

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) step("t3_fill", 1, 0, 0, 32'h200 + 16 * i, rnd128());
    check_val("t3_full", full, 1'b1);
    check_val("t3_count8", out_count, 4'd8);
    step("t3_ovf", 1, 0, 0, 32'hDEAD_0000, rnd128());
    for (int i = 0; i < DEPTH; i++) begin
      check_val("t3_order", out_pc, 32'h200 + 16 * i);
      step("t3_drain", 0, 1, 0, 0, 0);
    end
    check_val("t3_empty", valid, 1'b0);

    // Full with read+write: write dropped
    for (int i = 0; i < DEPTH; i++) step("t4_fill", 1, 0, 0, 32'h300 + 4 * i, rnd128());
    step("t4_rw_full", 1, 1, 0, 32'hBAD0_0000, rnd128());
    check_val("t4_count7", out_count, 4'd7);
    for (int i = 0; i < 3; i++) step("t4_trim", 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("t4_wrap", 1, 1, 0, $urandom, rnd128());
    check_val("t4_count4", out_count, 4'd4);

    // Flush with simultaneous read and write at count 5
    step("t5_fill", 1, 0, 0, 32'h400, rnd128());
    check_val("t5_count5", out_count, 4'd5);
    step("t5_flush", 1, 1, 1, 32'h500, rnd128());
    check_val("t5_count0", out_count, 4'd0);
    step("t5_after", 1, 0, 0, 32'h604, rnd128());
    check_val("t5_head", out_pc, 32'h604);

    // Asynchronous reset mid-operation
    step("t6_fill", 1, 0, 0, 32'h700, rnd128());
    step("t6_fill", 1, 0, 0, 32'h710, rnd128());
    check_val("t6_count3", out_count, 4'd3);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    check_outputs("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step("t6_resume", 1, 0, 0, 32'h800 + 8 * i, rnd128());
    for (int i = 0; i < 4; i++) step("t6_drain", 0, 1, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 5),
           ($urandom_range(99, 0) < 3), $urandom, rnd128());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
